// File: rtl/imem_program_loader.sv
`default_nettype none
// ============================================================================
// Module  : imem_program_loader
// Brief   : Packs host-supplied instruction fields into 16-bit words, streams
//           them into instruction memory and holds the core in reset meanwhile.
// Revision: 1.0 - initial release
// ============================================================================
module imem_program_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [2:0]        in_ra,
    input  logic [2:0]        in_rb,
    input  logic [2:0]        in_rc,
    input  logic [1:0]        in_funct,
    input  logic [10:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              full,
    output logic              err_illegal,
    output logic              err_range,
    output logic              cpu_rst_n
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] c_base      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   c_limit     = (ADDR_W+1)'((1 << ADDR_W) - BASE_ADDR);
    localparam logic [ADDR_W:0]   c_cnt_one   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);

    state_t              r_state;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_wdata;
    logic [ADDR_W:0]     r_count;
    logic                r_full;
    logic                r_err_illegal;
    logic                r_err_range;
    logic                r_cpu_rst_n;

    logic                w_legal;
    logic                w_range_ok;
    logic [15:0]         w_word;
    logic                w_ready;
    logic                w_accept;
    logic [ADDR_W:0]     w_count_next;

    // Opcode-to-format decode; the range check asks whether the discarded
    // immediate bits are pure sign extension of the kept field.
    always_comb begin
        w_legal    = 1'b1;
        w_range_ok = 1'b1;
        w_word     = 16'h0000;
        case (in_opcode)
            5'b00000, 5'b00110, 5'b01011: begin
                w_word = {in_opcode, in_ra, in_rb, in_rc, in_funct};
            end
            5'b00001, 5'b00010, 5'b11000, 5'b11001: begin
                w_word     = {in_opcode, in_ra, in_imm[7:0]};
                w_range_ok = (&in_imm[10:7]) | ~(|in_imm[10:7]);
            end
            5'b00011, 5'b00101, 5'b00111, 5'b01000: begin
                w_word     = {in_opcode, in_ra, in_rb, in_imm[4:0]};
                w_range_ok = (&in_imm[10:4]) | ~(|in_imm[10:4]);
            end
            5'b10000, 5'b10001: begin
                w_word = {in_opcode, in_imm};
            end
            5'b10010, 5'b10011, 5'b11100: begin
                w_word = {in_opcode, in_ra, in_rb, 5'b00000};
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    assign w_ready      = (r_state == S_LOAD) & ~r_full;
    assign w_accept     = w_ready & in_valid;
    assign w_count_next = r_count + c_cnt_one;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_we          <= 1'b0;
            r_addr        <= c_base;
            r_wdata       <= 16'h0000;
            r_count       <= '0;
            r_full        <= 1'b0;
            r_err_illegal <= 1'b0;
            r_err_range   <= 1'b0;
            r_cpu_rst_n   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            // The address presented with a write advances once that write retires.
            if (r_we) begin
                r_addr <= r_addr + c_addr_one;
            end
            case (r_state)
                S_IDLE: begin
                    r_addr        <= c_base;
                    r_count       <= '0;
                    r_full        <= 1'b0;
                    r_err_illegal <= 1'b0;
                    r_err_range   <= 1'b0;
                    r_cpu_rst_n   <= 1'b0;
                    if (load_start) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        if (w_legal) begin
                            r_we    <= 1'b1;
                            r_wdata <= w_word;
                            r_count <= w_count_next;
                            r_full  <= (w_count_next == c_limit);
                            if (!w_range_ok) begin
                                r_err_range <= 1'b1;
                            end
                        end else begin
                            r_err_illegal <= 1'b1;
                        end
                    end
                    if (load_done) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_state     <= S_RUN;
                    r_cpu_rst_n <= 1'b1;
                end
                S_RUN: begin
                    if (load_start) begin
                        r_state       <= S_LOAD;
                        r_cpu_rst_n   <= 1'b0;
                        r_addr        <= c_base;
                        r_count       <= '0;
                        r_full        <= 1'b0;
                        r_err_illegal <= 1'b0;
                        r_err_range   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = w_ready;
    assign imem_we     = r_we;
    assign imem_addr   = r_addr;
    assign imem_wdata  = r_wdata;
    assign word_count  = r_count;
    assign full        = r_full;
    assign err_illegal = r_err_illegal;
    assign err_range   = r_err_range;
    assign cpu_rst_n   = r_cpu_rst_n;

endmodule
`default_nettype wire

// File: tb/tb_imem_program_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_imem_program_loader
// Brief   : Directed plus randomized bench for imem_program_loader against a
//           cycle-level reference model of the loader session.
// Revision: 1.0 - initial release
// ============================================================================
module tb_imem_program_loader;

    localparam int ADDR_W    = 2;
    localparam int BASE_ADDR = 0;
    localparam int DEPTH     = 1 << ADDR_W;
    localparam int LIMIT     = DEPTH - BASE_ADDR;

    localparam int P_IDLE  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_DRAIN = 2;
    localparam int P_RUN   = 3;

    localparam int F_ILL = 0;
    localparam int F_R   = 1;
    localparam int F_I8  = 2;
    localparam int F_I5  = 3;
    localparam int F_J   = 4;
    localparam int F_RR  = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_start = 1'b0;
    logic              load_done = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [4:0]        in_opcode = '0;
    logic [2:0]        in_ra = '0;
    logic [2:0]        in_rb = '0;
    logic [2:0]        in_rc = '0;
    logic [1:0]        in_funct = '0;
    logic [10:0]       in_imm = '0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic [ADDR_W:0]   word_count;
    logic              full;
    logic              err_illegal;
    logic              err_range;
    logic              cpu_rst_n;

    always #5 clk = ~clk;

    imem_program_loader #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .load_done   (load_done),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_ra       (in_ra),
        .in_rb       (in_rb),
        .in_rc       (in_rc),
        .in_funct    (in_funct),
        .in_imm      (in_imm),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .word_count  (word_count),
        .full        (full),
        .err_illegal (err_illegal),
        .err_range   (err_range),
        .cpu_rst_n   (cpu_rst_n)
    );

    int checks = 0;
    int errors = 0;

    // Reference session model: phase, words written, pending write, sticky flags.
    int          m_ph;
    int          m_cnt;
    bit          m_we;
    logic [15:0] m_wdata;
    bit          m_eill;
    bit          m_erng;

    int legal_ops[16] = '{0, 6, 11, 1, 2, 24, 25, 3, 5, 7, 8, 16, 17, 18, 19, 28};

    function automatic int fmt_of(input int op);
        case (op)
            0, 6, 11:       return F_R;
            1, 2, 24, 25:   return F_I8;
            3, 5, 7, 8:     return F_I5;
            16, 17:         return F_J;
            18, 19, 28:     return F_RR;
            default:        return F_ILL;
        endcase
    endfunction

    function automatic int signed_imm(input int imm);
        return (imm >= 1024) ? imm - 2048 : imm;
    endfunction

    function automatic int ref_word(input int op, input int ra, input int rb, input int rc,
                                    input int fn, input int imm);
        case (fmt_of(op))
            F_R:     return op * 2048 + ra * 256 + rb * 32 + rc * 4 + fn;
            F_I8:    return op * 2048 + ra * 256 + (imm % 256);
            F_I5:    return op * 2048 + ra * 256 + rb * 32 + (imm % 32);
            F_J:     return op * 2048 + imm;
            F_RR:    return op * 2048 + ra * 256 + rb * 32;
            default: return 0;
        endcase
    endfunction

    function automatic bit ref_fits(input int op, input int imm);
        int v;
        v = signed_imm(imm);
        case (fmt_of(op))
            F_I8:    return (v >= -128) && (v <= 127);
            F_I5:    return (v >= -16) && (v <= 15);
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit m_full();
        return m_cnt == LIMIT;
    endfunction

    function automatic bit m_ready();
        return (m_ph == P_LOAD) && !m_full();
    endfunction

    function automatic int m_addr();
        return (BASE_ADDR + m_cnt - (m_we ? 1 : 0)) % DEPTH;
    endfunction

    task automatic model_reset();
        m_ph    = P_IDLE;
        m_cnt   = 0;
        m_we    = 1'b0;
        m_wdata = 16'h0000;
        m_eill  = 1'b0;
        m_erng  = 1'b0;
    endtask

    task automatic model_clear();
        m_cnt  = 0;
        m_eill = 1'b0;
        m_erng = 1'b0;
    endtask

    task automatic model_edge();
        bit acc;
        bit we_n;
        acc  = m_ready() && in_valid;
        we_n = 1'b0;
        case (m_ph)
            P_IDLE: begin
                if (load_start) begin
                    model_clear();
                    m_ph = P_LOAD;
                end
            end
            P_LOAD: begin
                if (acc) begin
                    if (fmt_of(int'(in_opcode)) != F_ILL) begin
                        we_n    = 1'b1;
                        m_wdata = 16'(ref_word(int'(in_opcode), int'(in_ra), int'(in_rb),
                                               int'(in_rc), int'(in_funct), int'(in_imm)));
                        m_cnt   = m_cnt + 1;
                        if (!ref_fits(int'(in_opcode), int'(in_imm))) m_erng = 1'b1;
                    end else begin
                        m_eill = 1'b1;
                    end
                end
                if (load_done) m_ph = P_DRAIN;
            end
            P_DRAIN: m_ph = P_RUN;
            default: begin
                if (load_start) begin
                    model_clear();
                    m_ph = P_LOAD;
                end
            end
        endcase
        m_we = we_n;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("in_ready",    32'(in_ready),    32'(m_ready()));
        chk("imem_we",     32'(imem_we),     32'(m_we));
        chk("imem_addr",   32'(imem_addr),   32'(m_addr()));
        chk("imem_wdata",  32'(imem_wdata),  32'(m_wdata));
        chk("word_count",  32'(word_count),  32'(m_cnt));
        chk("full",        32'(full),        32'(m_full()));
        chk("err_illegal", 32'(err_illegal), 32'(m_eill));
        chk("err_range",   32'(err_range),   32'(m_erng));
        chk("cpu_rst_n",   32'(cpu_rst_n),   32'(m_ph == P_RUN));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        #1;
        check_all();
    endtask

    task automatic bundle(input bit v, input int op, input int ra, input int rb,
                          input int rc, input int fn, input int imm);
        in_valid  = v;
        in_opcode = 5'(op);
        in_ra     = 3'(ra);
        in_rb     = 3'(rb);
        in_rc     = 3'(rc);
        in_funct  = 2'(fn);
        in_imm    = 11'(imm);
    endtask

    initial begin
        int n;
        model_reset();
        repeat (2) tick();
        chk("reset_addr", 32'(imem_addr), 32'(BASE_ADDR));
        rst_n = 1'b1;
        repeat (2) tick();

        // ADDI then R-type, back-to-back
        load_start = 1'b1; tick(); load_start = 1'b0;
        bundle(1, 7, 3, 1, 0, 0, 5); tick();
        chk("t1_we", 32'(imem_we), 32'd1);
        chk("t1_addr", 32'(imem_addr), 32'd0);
        chk("t1_wdata", 32'(imem_wdata), 32'h3B25);
        chk("t1_count", 32'(word_count), 32'd1);
        bundle(1, 0, 2, 3, 4, 1, 0); tick();
        chk("t2_we", 32'(imem_we), 32'd1);
        chk("t2_addr", 32'(imem_addr), 32'd1);
        chk("t2_wdata", 32'(imem_wdata), 32'h0271);

        // Illegal opcode: accepted, not written
        bundle(1, 4, 1, 1, 1, 1, 9); tick();
        chk("t3_we", 32'(imem_we), 32'd0);
        chk("t3_err_illegal", 32'(err_illegal), 32'd1);
        chk("t3_count", 32'(word_count), 32'd2);
        chk("t3_addr", 32'(imem_addr), 32'd2);
        bundle(1, 1, 1, 0, 0, 0, 3); tick();
        chk("t3_next_addr", 32'(imem_addr), 32'd2);
        chk("t3_next_count", 32'(word_count), 32'd3);

        // One slot left: an illegal opcode must not consume it
        bundle(1, 31, 0, 0, 0, 0, 0); tick();
        chk("t4_slot_count", 32'(word_count), 32'd3);
        chk("t4_slot_ready", 32'(in_ready), 32'd1);
        bundle(1, 3, 0, 0, 0, 0, 16); tick();
        chk("t4_wdata", 32'(imem_wdata), 32'h1810);
        chk("t4_err_range", 32'(err_range), 32'd1);
        chk("t5_full", 32'(full), 32'd1);
        chk("t5_ready", 32'(in_ready), 32'd0);
        tick();
        chk("t5_no_write_when_full", 32'(imem_we), 32'd0);
        bundle(0, 0, 0, 0, 0, 0, 0);

        // Release and restart
        load_done = 1'b1; tick(); load_done = 1'b0;
        chk("t5_drain_cpu", 32'(cpu_rst_n), 32'd0);
        tick();
        chk("t5_run_cpu", 32'(cpu_rst_n), 32'd1);
        load_done = 1'b1; tick(); load_done = 1'b0;
        load_start = 1'b1; tick(); load_start = 1'b0;
        chk("t5_restart_cpu", 32'(cpu_rst_n), 32'd0);
        chk("t5_restart_count", 32'(word_count), 32'd0);
        chk("t5_restart_full", 32'(full), 32'd0);
        chk("t5_restart_err", 32'({err_illegal, err_range}), 32'd0);

        // Negative immediate that fits
        bundle(1, 3, 0, 0, 0, 0, 11'h7F0); tick();
        chk("t4b_wdata", 32'(imem_wdata), 32'h1810);
        chk("t4b_err_range", 32'(err_range), 32'd0);

        // Reset with a write pending
        bundle(1, 16, 0, 0, 0, 0, 1234); tick();
        bundle(1, 28, 5, 6, 0, 0, 0); tick();
        chk("t6_pending_we", 32'(imem_we), 32'd1);
        rst_n = 1'b0; #1;
        model_reset();
        check_all();
        chk("t6_abort_we", 32'(imem_we), 32'd0);
        chk("t6_abort_count", 32'(word_count), 32'd0);
        bundle(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized sessions
        for (int s = 0; s < 40; s++) begin
            load_start = 1'b1; tick(); load_start = 1'b0;
            n = $urandom_range(3, 14);
            for (int c = 0; c < n; c++) begin
                bundle($urandom_range(0, 3) != 0,
                       ($urandom_range(0, 4) == 0) ? $urandom_range(0, 31)
                                                   : legal_ops[$urandom_range(0, 15)],
                       $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                       $urandom_range(0, 3), $urandom_range(0, 2047));
                load_start = ($urandom_range(0, 9) == 0);
                tick();
            end
            load_start = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                rst_n = 1'b0; #1;
                model_reset();
                check_all();
                tick();
                rst_n = 1'b1;
                in_valid = 1'b0;
                tick();
            end else begin
                load_done = 1'b1; tick(); load_done = 1'b0;
                in_valid = $urandom_range(0, 1);
                tick();
                in_valid = 1'b0;
                repeat (2) begin
                    load_done = $urandom_range(0, 1);
                    tick();
                end
                load_done = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Writer-side counterpart of the CPU instruction decode path.
- Accepts instruction fields (opcode plus operands) from a host or debug front-end over a valid/ready handshake.
- Packs the fields into 16-bit instruction words in the format the core decodes from bits [15:11], and writes them sequentially into instruction memory.
- Holds the core in reset while loading and releases it when loading completes.

Parameters:
ADDR_W, 8, instruction-memory address width; depth is 2**ADDR_W words
BASE_ADDR, 0, first write address after load_start

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  asynchronous active-low reset
load_start  in  1  one-cycle pulse; begin a new load session
load_done  in  1  one-cycle pulse; end the session
in_valid  in  1  field bundle valid
in_ready  out  1  loader can accept a bundle
in_opcode  in  5  opcode, placed in word[15:11]
in_ra  in  3  operand A (rd or cond)
in_rb  in  3  operand B
in_rc  in  3  operand C
in_funct  in  2  R-type function
in_imm  in  11  signed immediate, two's complement
imem_we  out  1  instruction-memory write strobe
imem_addr  out  ADDR_W  write address
imem_wdata  out  16  encoded instruction
word_count  out  ADDR_W+1  words written this session
full  out  1  memory exhausted
err_illegal  out  1  sticky; an illegal opcode was offered
err_range  out  1  sticky; an immediate was truncated
cpu_rst_n  out  1  core reset; low while loading

Behaviour:
Interface and reset:
- One clock; reset is asynchronous and active-low.
- While rst_n=0: state=IDLE, in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, word_count=0, full=0, err_illegal=0, err_range=0, cpu_rst_n=0.

State machine (IDLE, LOAD, DRAIN, RUN):
- IDLE:
  - load_start -> LOAD.
  - Clears word_count, full and both error flags.
  - Sets the next-write address to BASE_ADDR.
  - cpu_rst_n stays 0.
- LOAD:
  - in_ready = ~full.
  - A bundle is accepted when in_valid & in_ready.
  - Encoding is registered: for a bundle accepted at cycle N, imem_we=1 in cycle N+1 with imem_addr and imem_wdata valid.
  - Back-to-back accepts give back-to-back writes.
  - On load_done -> DRAIN. A bundle accepted in the same cycle as load_done is still written.
- DRAIN:
  - in_ready=0.
  - Finishes any pending write, then -> RUN the next cycle.
- RUN:
  - cpu_rst_n=1; in_ready=0.
  - load_start -> LOAD with the same clearing as IDLE.
  - cpu_rst_n drops to 0 in the cycle after the load_start pulse.
- load_done outside LOAD is ignored. load_start inside LOAD or DRAIN is ignored.

Encoding (all unused bits = 0):
- R format, opcodes 00000, 00110, 01011: [10:8]=ra, [7:5]=rb, [4:2]=rc, [1:0]=funct.
- I8 format, opcodes 00001, 00010, 11000, 11001: [10:8]=ra, [7:0]=imm[7:0]. Range check: imm[10:7] all equal.
- I5 format, opcodes 00011, 00101, 00111, 01000: [10:8]=ra, [7:5]=rb, [4:0]=imm[4:0]. Range check: imm[10:4] all equal.
- J11 format, opcodes 10000, 10001: [10:0]=imm.
- RR format, opcodes 10010, 10011, 11100: [10:8]=ra, [7:5]=rb, [4:0]=0.

Error and counting rules:
- Any other opcode is illegal:
  - The bundle is accepted (handshake completes) but not written.
  - err_illegal is set; address and count are unchanged.
- A failed range check still writes the truncated word and sets err_range.
- Each write increments imem_addr (wrapping within ADDR_W bits) and word_count.
- full=1 once word_count reaches 2**ADDR_W - BASE_ADDR. While full, in_ready=0.

Boundary cases:
- An illegal opcode while exactly one slot remains does not consume the slot.
- Reset mid-session aborts immediately: a pending write is dropped and the core stays in reset.

Test Plan:
1. Write ADDI. load_start, then bundle opcode=00111, ra=3, rb=1, imm=5 -> next cycle imem_we=1, imem_addr=0, imem_wdata=0x3B25, word_count=1.
2. Write R-type, back-to-back with the scenario-1 bundle. Bundle opcode=00000, ra=2, rb=3, rc=4, funct=1 -> imem_wdata=0x0271 at imem_addr=1 in consecutive write cycles.
3. Illegal opcode. opcode=00100 -> handshake completes, no imem_we, err_illegal=1, address and count unchanged; the next legal word goes to the unchanged address.
4. Range error. LDR opcode=00011, ra=0, rb=0, imm=16 -> imem_wdata=0x1810, err_range=1. A second LDR with imm=0x7F0 (-16) -> no new range error, low bits 10000.
5. Fill and release, with ADDR_W=2:
   - Send 4 legal words -> full=1 and in_ready=0 after the 4th accept.
   - Pulse load_done -> DRAIN, then RUN; cpu_rst_n=1 two cycles after load_done.
   - Pulse load_start -> cpu_rst_n=0, count and flags cleared.
6. Reset mid-load. Drop rst_n after 2 words, with one bundle accepted that cycle -> all outputs at reset values immediately, no write of the pending bundle.
